// File: rtl/game_state_ctrl.sv
// game_state_ctrl: Flappy-Bird game sequencer with score tracking and frame-counted dwell timers
module game_state_ctrl #(
    parameter int DEATH_FRAMES     = 60,
    parameter int OVER_HOLD_FRAMES = 30,
    parameter int SCORE_MAX        = 999
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       flap_btn,
    input  logic       collision,
    input  logic       pipe_passed,
    output logic [1:0] state,
    output logic       world_en,
    output logic       game_rst,
    output logic       flap_pulse,
    output logic       game_over,
    output logic [9:0] score,
    output logic [9:0] best_score
);
    typedef enum logic [1:0] {IDLE, PLAYING, DYING, OVER} state_t;
    state_t     cur, nxt;
    logic [7:0] cnt, cnt_n;
    logic [9:0] score_n, best_n;
    logic       armed, armed_n, flap_q, rise, hit, start;
    assign state = cur;
    assign rise  = flap_btn & ~flap_q;
    assign hit   = collision & armed;
    always_comb begin
        nxt     = cur;
        cnt_n   = cnt;
        armed_n = armed;
        score_n = score;
        best_n  = best_score;
        start   = 1'b0;
        case (cur)
            IDLE: start = rise;
            PLAYING: begin
                armed_n = armed | frame_tick;
                if (hit) begin
                    nxt   = DYING;
                    cnt_n = '0;
                end else if (pipe_passed && score < 10'(SCORE_MAX))
                    score_n = score + 10'd1;
            end
            DYING: if (frame_tick) begin
                if ({1'b0, cnt} + 9'd1 == 9'(DEATH_FRAMES)) begin
                    nxt    = OVER;
                    cnt_n  = '0;
                    best_n = score > best_score ? score : best_score;
                end else
                    cnt_n = cnt + 8'd1;
            end
            OVER: begin
                start = rise && ({1'b0, cnt} >= 9'(OVER_HOLD_FRAMES));
                if (frame_tick && {1'b0, cnt} < 9'(OVER_HOLD_FRAMES))
                    cnt_n = cnt + 8'd1;
            end
            default: nxt = IDLE;
        endcase
        if (start) begin
            nxt     = PLAYING;
            armed_n = 1'b0;
            score_n = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur        <= IDLE;
            cnt        <= '0;
            armed      <= 1'b0;
            flap_q     <= 1'b1;
            score      <= '0;
            best_score <= '0;
            world_en   <= 1'b0;
            game_rst   <= 1'b0;
            flap_pulse <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            cur        <= nxt;
            cnt        <= cnt_n;
            armed      <= armed_n;
            flap_q     <= flap_btn;
            score      <= score_n;
            best_score <= best_n;
            world_en   <= nxt == PLAYING;
            game_rst   <= start;
            flap_pulse <= cur == PLAYING && rise && !game_rst;
            game_over  <= nxt == OVER;
        end
    end
endmodule
